// File: rtl/sdram_port_arbiter.sv
// Two-client SDRAM command-port arbiter: round-robin whole-burst grants, write beat streaming, read beat routing.
// Optional read timeout watchdog enabled with `define ARBITER_RD_TIMEOUT_EN.
module sdram_port_arbiter #(
   parameter int ADDR_WIDTH  = 21,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WORDS = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int RD_TIMEOUT  = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    mem_init_done,
   input  logic                    c0_req,
   input  logic [ADDR_WIDTH-1:0]   c0_addr,
   input  logic [DATA_WIDTH-1:0]   c0_wr_data,
   input  logic [DATA_WIDTH/8-1:0] c0_data_mask,
   output logic                    c0_grant,
   output logic                    c0_wr_ack,
   output logic                    c0_done,
   input  logic                    c1_req,
   input  logic [ADDR_WIDTH-1:0]   c1_addr,
   output logic                    c1_grant,
   output logic [DATA_WIDTH-1:0]   c1_rd_data,
   output logic                    c1_rd_data_valid,
   output logic                    c1_done,
   output logic                    mem_cmd,
   output logic                    mem_cmd_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   output logic [DATA_WIDTH/8-1:0] mem_data_mask,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   input  logic                    mem_rd_data_valid,
   output logic                    error
);

   typedef enum logic [2:0] {
      INIT, IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT, GAP
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(BURST_WORDS - 1);
   localparam logic [3:0] LAST_GAP  = 4'(GAP_CYCLES - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic                  last_grant, last_grant_nxt;
   logic                  owner, owner_nxt;
   logic [7:0]            beat_cnt, beat_cnt_nxt;
   logic [3:0]            gap_cnt, gap_cnt_nxt;
   logic                  error_q, error_nxt;
   logic                  rd_timeout;

`ifdef ARBITER_RD_TIMEOUT_EN
   localparam int TO_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(RD_TIMEOUT);

   logic [TO_W-1:0] to_cnt;

   // Cycles elapsed since the read command; holds at the limit until the burst is abandoned
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
      end else if (state == RD_CMD) begin
         to_cnt <= TO_W'(1);
      end else if (state == RD_WAIT && to_cnt != TO_LIMIT) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign rd_timeout = (state == RD_WAIT) && (to_cnt == TO_LIMIT);
`else
   // Watchdog absent: never fires
   assign rd_timeout = (RD_TIMEOUT < 0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= INIT;
         addr_q     <= '0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         beat_cnt   <= '0;
         gap_cnt    <= '0;
         error_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr_q     <= addr_nxt;
         last_grant <= last_grant_nxt;
         owner      <= owner_nxt;
         beat_cnt   <= beat_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         error_q    <= error_nxt;
      end
   end

   // Read beats are only legal while a read burst is waiting for data
   always_comb begin
      state_nxt        = state;
      addr_nxt         = addr_q;
      last_grant_nxt   = last_grant;
      owner_nxt        = owner;
      beat_cnt_nxt     = beat_cnt;
      gap_cnt_nxt      = gap_cnt;
      error_nxt        = error_q | (mem_rd_data_valid && state != RD_WAIT);
      c0_grant         = 1'b0;
      c0_wr_ack        = 1'b0;
      c0_done          = 1'b0;
      c1_grant         = 1'b0;
      c1_rd_data       = '0;
      c1_rd_data_valid = 1'b0;
      c1_done          = 1'b0;
      mem_cmd          = 1'b0;
      mem_cmd_en       = 1'b0;
      mem_addr         = '0;
      mem_wr_data      = '0;
      mem_data_mask    = '0;

      case (state)
         INIT: begin
            if (mem_init_done) state_nxt = IDLE;
         end
         IDLE: begin
            beat_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
            // On a tie the writer wins unless it was the last one served
            if (c0_req && (!c1_req || last_grant)) begin
               state_nxt      = WR_CMD;
               addr_nxt       = c0_addr;
               last_grant_nxt = 1'b0;
               owner_nxt      = 1'b0;
            end else if (c1_req) begin
               state_nxt      = RD_CMD;
               addr_nxt       = c1_addr;
               last_grant_nxt = 1'b1;
               owner_nxt      = 1'b1;
            end
         end
         WR_CMD: begin
            c0_grant      = 1'b1;
            c0_wr_ack     = 1'b1;
            mem_cmd_en    = 1'b1;
            mem_cmd       = 1'b1;
            mem_addr      = addr_q;
            mem_wr_data   = c0_wr_data;
            mem_data_mask = c0_data_mask;
            beat_cnt_nxt  = 8'd1;
            state_nxt     = (BURST_WORDS > 1) ? WR_DATA : GAP;
         end
         WR_DATA: begin
            c0_grant      = 1'b1;
            c0_wr_ack     = 1'b1;
            mem_wr_data   = c0_wr_data;
            mem_data_mask = c0_data_mask;
            beat_cnt_nxt  = beat_cnt + 8'd1;
            if (beat_cnt == LAST_BEAT) state_nxt = GAP;
         end
         RD_CMD: begin
            c1_grant     = 1'b1;
            mem_cmd_en   = 1'b1;
            mem_addr     = addr_q;
            beat_cnt_nxt = '0;
            state_nxt    = RD_WAIT;
         end
         RD_WAIT: begin
            c1_grant         = 1'b1;
            c1_rd_data       = mem_rd_data;
            c1_rd_data_valid = mem_rd_data_valid;
            // A final beat arriving on the timeout cycle still completes the burst cleanly
            if (mem_rd_data_valid) begin
               if (beat_cnt == LAST_BEAT) state_nxt = GAP;
               else                       beat_cnt_nxt = beat_cnt + 8'd1;
            end else if (rd_timeout) begin
               error_nxt = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            beat_cnt_nxt = '0;
            gap_cnt_nxt  = gap_cnt + 4'd1;
            if (gap_cnt == 4'd0) begin
               c0_done = !owner;
               c1_done = owner;
            end
            if (gap_cnt == LAST_GAP) state_nxt = IDLE;
         end
         default: state_nxt = INIT;
      endcase
   end

   assign error = error_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: scoreboarded write/read beats, arbitration order, error and reset behaviour.
module tb_sdram_port_arbiter;

   localparam int AW = 21;
   localparam int DW = 32;
   localparam int MW = DW / 8;
   localparam int BW = 8;
   localparam int GC = 2;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          mem_init_done;
   logic          c0_req;
   logic [AW-1:0] c0_addr;
   logic [DW-1:0] c0_wr_data;
   logic [MW-1:0] c0_data_mask;
   logic          c0_grant, c0_wr_ack, c0_done;
   logic          c1_req;
   logic [AW-1:0] c1_addr;
   logic          c1_grant;
   logic [DW-1:0] c1_rd_data;
   logic          c1_rd_data_valid, c1_done;
   logic          mem_cmd, mem_cmd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic [MW-1:0] mem_data_mask;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_data_valid;
   logic          error;

   sdram_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WORDS(BW), .GAP_CYCLES(GC), .RD_TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mem_init_done(mem_init_done),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_wr_data(c0_wr_data), .c0_data_mask(c0_data_mask),
      .c0_grant(c0_grant), .c0_wr_ack(c0_wr_ack), .c0_done(c0_done),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_grant(c1_grant), .c1_rd_data(c1_rd_data),
      .c1_rd_data_valid(c1_rd_data_valid), .c1_done(c1_done),
      .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
      .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid), .error(error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [DW-1:0] wr_q_data[$];
   logic [MW-1:0] wr_q_mask[$];
   logic [DW-1:0] exp_wr_data[$];
   logic [MW-1:0] exp_wr_mask[$];
   logic [DW-1:0] exp_rd[$];
   logic          rd_sched_v[$];
   logic [DW-1:0] rd_sched_d[$];
   logic [DW-1:0] rd_base = 32'h5000_0000;

   bit            mem_silent   = 1'b0;
   logic          inject_valid = 1'b0;
   logic [DW-1:0] inject_data  = '0;

   int            cmd_count, wr_ack_count, rd_valid_count, c0_done_count, c1_done_count;
   int            first_ack_cyc, last_ack_cyc;
   logic          last_cmd;
   logic [AW-1:0] last_addr;
   int            grant_log[$];
   int            cmd_cyc_log[$];

   task automatic clear_monitors();
      cmd_count = 0; wr_ack_count = 0; rd_valid_count = 0;
      c0_done_count = 0; c1_done_count = 0;
      first_ack_cyc = 0; last_ack_cyc = 0;
      last_cmd = 1'b0; last_addr = '0;
      grant_log.delete(); cmd_cyc_log.delete();
   endtask

   // Memory model: 4-cycle latency to first beat, one bubble after beat 3
   task automatic schedule_read();
      for (int i = 0; i < 3; i++) begin
         rd_sched_v.push_back(1'b0); rd_sched_d.push_back('0);
      end
      for (int i = 0; i < BW; i++) begin
         if (i == 4) begin
            rd_sched_v.push_back(1'b0); rd_sched_d.push_back('0);
         end
         rd_sched_v.push_back(1'b1); rd_sched_d.push_back(rd_base + DW'(i));
      end
      rd_base = rd_base + 32'h100;
   endtask

   task automatic load_write_burst(input logic [DW-1:0] base);
      for (int i = 0; i < BW; i++) begin
         wr_q_data.push_back(base + DW'(i));
         wr_q_mask.push_back(MW'(i) ^ 4'hF);
         exp_wr_data.push_back(base + DW'(i));
         exp_wr_mask.push_back(MW'(i) ^ 4'hF);
      end
   endtask

   // One clock: drive inputs 1ns after the edge, sample and score 1ns later
   task automatic apply_stimulus();
      logic [DW-1:0] d;
      logic [MW-1:0] m;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_sched_v.size() > 0) begin
         mem_rd_data_valid = rd_sched_v.pop_front();
         mem_rd_data       = rd_sched_d.pop_front();
         if (mem_rd_data_valid) exp_rd.push_back(mem_rd_data);
      end else begin
         mem_rd_data_valid = inject_valid;
         mem_rd_data       = inject_data;
      end
      c0_wr_data   = (wr_q_data.size() > 0) ? wr_q_data[0] : '0;
      c0_data_mask = (wr_q_mask.size() > 0) ? wr_q_mask[0] : '0;
      #1;
      if (mem_cmd_en) begin
         cmd_count++;
         last_cmd  = mem_cmd;
         last_addr = mem_addr;
         grant_log.push_back(mem_cmd ? 0 : 1);
         cmd_cyc_log.push_back(cyc);
         if (!mem_cmd && !mem_silent) schedule_read();
      end
      if (c0_wr_ack) begin
         if (wr_ack_count == 0) first_ack_cyc = cyc;
         last_ack_cyc = cyc;
         wr_ack_count++;
         if (wr_q_data.size() > 0) begin
            void'(wr_q_data.pop_front());
            void'(wr_q_mask.pop_front());
         end
         n_checks++;
         if (exp_wr_data.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL wr_beat: unexpected ack, mem_wr_data=%0h, no beat expected", mem_wr_data);
         end else begin
            d = exp_wr_data.pop_front();
            m = exp_wr_mask.pop_front();
            if ({mem_wr_data, mem_data_mask} !== {d, m}) begin
               n_fail++;
               $display("[TB] FAIL wr_beat: got data %0h mask %0h, expected data %0h mask %0h",
                        mem_wr_data, mem_data_mask, d, m);
            end
         end
      end
      if (c1_rd_data_valid) begin
         rd_valid_count++;
         n_checks++;
         if (exp_rd.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL rd_beat: unexpected beat %0h, none expected", c1_rd_data);
         end else begin
            d = exp_rd.pop_front();
            if (c1_rd_data !== d) begin
               n_fail++;
               $display("[TB] FAIL rd_beat: got %0h, expected %0h", c1_rd_data, d);
            end
         end
      end
      if (c0_done) c0_done_count++;
      if (c1_done) c1_done_count++;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      c0_req = 1'b0; c1_req = 1'b0;
      inject_valid = 1'b0; mem_silent = 1'b0;
      rd_sched_v.delete(); rd_sched_d.delete();
      wr_q_data.delete(); wr_q_mask.delete();
      exp_wr_data.delete(); exp_wr_mask.delete(); exp_rd.delete();
      apply_stimulus();
      apply_stimulus();
      reset_n = 1'b1;
      mem_init_done = 1'b1;
      clear_monitors();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      mem_init_done = 1'b1;
      c0_req = 1'b1; c1_req = 1'b1;
      c0_addr = 21'h1F0F0; c1_addr = 21'h0ABCD;
      clear_monitors();
      apply_stimulus();
      apply_stimulus();
      n_checks++;
      if ({c0_grant, c1_grant, mem_cmd_en, mem_cmd} !== 4'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {c0_grant, c1_grant, mem_cmd_en, mem_cmd});
      end
      n_checks++;
      if (mem_addr !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_addr: got %0h, expected 0", mem_addr);
      end
      n_checks++;
      if ({c0_wr_ack, c0_done, c1_done, c1_rd_data_valid, error} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b, expected 00000",
                  {c0_wr_ack, c0_done, c1_done, c1_rd_data_valid, error});
      end
      c0_req = 1'b0; c1_req = 1'b0;
      mem_init_done = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_init_and_write();
      int waited;
      clear_monitors();
      c0_addr = 21'h4B020;
      load_write_burst(32'hA0);
      c0_req = 1'b1;
      for (int i = 0; i < 20; i++) apply_stimulus();
      n_checks++;
      if (cmd_count != 0 || c0_grant !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL init_gate: got %0d commands grant=%b, expected 0 commands grant=0", cmd_count, c0_grant);
      end
      mem_init_done = 1'b1;
      waited = 0;
      for (int i = 0; i < 10 && cmd_count == 0; i++) begin
         apply_stimulus();
         waited++;
      end
      n_checks++;
      if (waited != 2 || cmd_count != 1) begin
         n_fail++;
         $display("[TB] FAIL init_latency: got %0d cycles (%0d cmds), expected 2 cycles", waited, cmd_count);
      end
      for (int i = 0; i < 30 && c0_done_count == 0; i++) apply_stimulus();
      c0_req = 1'b0;
      for (int i = 0; i < 4; i++) apply_stimulus();
      n_checks++;
      if (cmd_count != 1 || last_cmd !== 1'b1 || last_addr !== 21'h4B020) begin
         n_fail++;
         $display("[TB] FAIL wr_cmd: got %0d cmds cmd=%b addr=%0h, expected 1 cmd cmd=1 addr=4b020",
                  cmd_count, last_cmd, last_addr);
      end
      n_checks++;
      if (wr_ack_count != BW || (last_ack_cyc - first_ack_cyc) != BW - 1) begin
         n_fail++;
         $display("[TB] FAIL wr_ack: got %0d acks over span %0d, expected %0d contiguous",
                  wr_ack_count, last_ack_cyc - first_ack_cyc, BW);
      end
      n_checks++;
      if (c0_done_count != 1 || c1_done_count != 0 || exp_wr_data.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL wr_done: got c0_done=%0d c1_done=%0d left=%0d, expected 1 0 0",
                  c0_done_count, c1_done_count, exp_wr_data.size());
      end
   endtask

   task automatic test_read_burst();
      clear_monitors();
      c1_addr = 21'h4B020;
      c1_req = 1'b1;
      for (int i = 0; i < 60 && c1_done_count == 0; i++) apply_stimulus();
      c1_req = 1'b0;
      for (int i = 0; i < 4; i++) apply_stimulus();
      n_checks++;
      if (cmd_count != 1 || last_cmd !== 1'b0 || last_addr !== 21'h4B020) begin
         n_fail++;
         $display("[TB] FAIL rd_cmd: got %0d cmds cmd=%b addr=%0h, expected 1 cmd cmd=0 addr=4b020",
                  cmd_count, last_cmd, last_addr);
      end
      n_checks++;
      if (rd_valid_count != BW || exp_rd.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL rd_count: got %0d beats (%0d unread), expected %0d", rd_valid_count, exp_rd.size(), BW);
      end
      n_checks++;
      if (c1_done_count != 1 || error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rd_done: got done=%0d error=%b, expected done=1 error=0", c1_done_count, error);
      end
   endtask

   task automatic test_round_robin();
      int exp_order[4] = '{0, 1, 0, 1};
      apply_reset();
      load_write_burst(32'hB0);
      load_write_burst(32'hC0);
      c0_addr = 21'h00100; c1_addr = 21'h00200;
      c0_req = 1'b1; c1_req = 1'b1;
      for (int i = 0; i < 200 && grant_log.size() < 4; i++) apply_stimulus();
      c0_req = 1'b0; c1_req = 1'b0;
      for (int i = 0; i < 40 && c1_done_count < 2; i++) apply_stimulus();
      for (int i = 0; i < 4; i++) apply_stimulus();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (grant_log.size() <= i) begin
            n_fail++;
            $display("[TB] FAIL rr_order[%0d]: got no grant, expected client %0d", i, exp_order[i]);
         end else if (grant_log[i] != exp_order[i]) begin
            n_fail++;
            $display("[TB] FAIL rr_order[%0d]: got client %0d, expected client %0d", i, grant_log[i], exp_order[i]);
         end
      end
      n_checks++;
      if (cmd_cyc_log.size() < 2 || (cmd_cyc_log[1] - cmd_cyc_log[0]) != 1 + BW + GC) begin
         n_fail++;
         $display("[TB] FAIL rr_spacing: got %0d cycles, expected %0d",
                  (cmd_cyc_log.size() < 2) ? -1 : cmd_cyc_log[1] - cmd_cyc_log[0], 1 + BW + GC);
      end
      n_checks++;
      if (c0_done_count != 2 || c1_done_count != 2 || rd_valid_count != 2 * BW || exp_wr_data.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL rr_totals: got c0_done=%0d c1_done=%0d rd=%0d wr_left=%0d, expected 2 2 %0d 0",
                  c0_done_count, c1_done_count, rd_valid_count, exp_wr_data.size(), 2 * BW);
      end
   endtask

   task automatic test_unexpected_beat();
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL err_pre: got %b, expected 0", error);
      end
      inject_valid = 1'b1;
      inject_data  = 32'hDEAD_BEEF;
      apply_stimulus();
      inject_valid = 1'b0;
      n_checks++;
      if (c1_rd_data_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL err_forward: got valid=%b, expected 0", c1_rd_data_valid);
      end
      apply_stimulus();
      n_checks++;
      if (error !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL err_set: got %b, expected 1", error);
      end
      for (int i = 0; i < 10; i++) apply_stimulus();
      n_checks++;
      if (error !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL err_sticky: got %b, expected 1", error);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL err_clear: got %b, expected 0", error);
      end
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      c1_addr = 21'h01234;
      c1_req = 1'b1;
      for (int i = 0; i < 40 && rd_valid_count < 3; i++) apply_stimulus();
      n_checks++;
      if (rd_valid_count != 3) begin
         n_fail++;
         $display("[TB] FAIL mid_read_beats: got %0d beats, expected 3", rd_valid_count);
      end
      reset_n = 1'b0;
      c1_req = 1'b0;
      rd_sched_v.delete(); rd_sched_d.delete();
      apply_stimulus();
      n_checks++;
      if ({c1_grant, c1_rd_data_valid, mem_cmd_en, c1_done, error} !== 5'b0 || mem_addr !== '0) begin
         n_fail++;
         $display("[TB] FAIL mid_read_reset: got flags %b addr %0h, expected 00000 addr 0",
                  {c1_grant, c1_rd_data_valid, mem_cmd_en, c1_done, error}, mem_addr);
      end
      apply_stimulus();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) apply_stimulus();
      n_checks++;
      if (c1_done_count != 0 || cmd_count != 1) begin
         n_fail++;
         $display("[TB] FAIL mid_read_done: got done=%0d cmds=%0d, expected done=0 cmds=1", c1_done_count, cmd_count);
      end
      exp_rd.delete();
   endtask

`ifdef ARBITER_RD_TIMEOUT_EN
   task automatic test_rd_timeout();
      int err_cyc;
      apply_reset();
      mem_silent = 1'b1;
      c1_addr = 21'h00777;
      c1_req = 1'b1;
      err_cyc = -1;
      for (int i = 0; i < TO + 30 && err_cyc < 0; i++) begin
         apply_stimulus();
         if (error === 1'b1) err_cyc = cyc;
      end
      c1_req = 1'b0;
      for (int i = 0; i < 6; i++) apply_stimulus();
      n_checks++;
      if (err_cyc < 0 || cmd_cyc_log.size() < 1 ||
          (err_cyc - cmd_cyc_log[0]) < TO || (err_cyc - cmd_cyc_log[0]) > TO + 2) begin
         n_fail++;
         $display("[TB] FAIL rd_timeout: got error at %0d cycles after cmd, expected %0d..%0d",
                  (err_cyc < 0 || cmd_cyc_log.size() < 1) ? -1 : err_cyc - cmd_cyc_log[0], TO, TO + 2);
      end
      n_checks++;
      if (c1_done_count != 1 || c1_grant !== 1'b0 || error !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rd_timeout_done: got done=%0d grant=%b error=%b, expected 1 0 1",
                  c1_done_count, c1_grant, error);
      end
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      mem_init_done = 1'b0;
      c0_req = 1'b0; c1_req = 1'b0;
      c0_addr = '0; c1_addr = '0;
      c0_wr_data = '0; c0_data_mask = '0;
      mem_rd_data = '0; mem_rd_data_valid = 1'b0;
      clear_monitors();
      $display("[TB] starting sdram_port_arbiter bench");
      test_reset();
      test_init_and_write();
      test_read_burst();
      test_round_robin();
      test_unexpected_beat();
      test_reset_mid_read();
`ifdef ARBITER_RD_TIMEOUT_EN
      test_rd_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
